// File: rtl/peripheral_dbg_tap_pkg.sv
// Shared TAP state encodings and instruction opcodes for the debug TAP controller.
package peripheral_dbg_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PDR   = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDR  = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PIR   = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPIR  = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_e;

  // Opcodes are width-independent integers; BYPASS is all-ones at any IR width.
  localparam int OPC_EXTEST         = 0;
  localparam int OPC_SAMPLE_PRELOAD = 1;
  localparam int OPC_IDCODE         = 2;
  localparam int OPC_USERCODE       = 3;

  function automatic int opc_bypass(input int ir_len);
    return (1 << ir_len) - 1;
  endfunction

endpackage

// File: rtl/peripheral_dbg_tap_multi_if.sv
// JTAG pad-side serial bundle: TMS/TDI into the TAP, TDO and its enable out.
interface peripheral_dbg_tap_multi_if;
  logic tms_pad_i;
  logic tdi_pad_i;
  logic tdo_pad_o;
  logic tdo_padoe_o;

  modport slave  (input tms_pad_i, input tdi_pad_i, output tdo_pad_o, output tdo_padoe_o);
  modport master (output tms_pad_i, output tdi_pad_i, input tdo_pad_o, input tdo_padoe_o);
endinterface

// File: rtl/peripheral_dbg_tap_fsm.sv
// 16-state 1149.1 TAP state machine with registered state and combinational decodes.
module peripheral_dbg_tap_fsm
  import peripheral_dbg_tap_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_e o_state,
  output logic       o_tlr,
  output logic       o_rti,
  output logic       o_capdr,
  output logic       o_shdr,
  output logic       o_pdr,
  output logic       o_updr
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) r_state <= TAP_TLR;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TAP_TLR:   w_next = i_tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   w_next = i_tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: w_next = i_tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: w_next = i_tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  w_next = i_tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: w_next = i_tms ? TAP_UPDR  : TAP_PDR;
      TAP_PDR:   w_next = i_tms ? TAP_EX2DR : TAP_PDR;
      TAP_EX2DR: w_next = i_tms ? TAP_UPDR  : TAP_SHDR;
      TAP_UPDR:  w_next = i_tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: w_next = i_tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: w_next = i_tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  w_next = i_tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: w_next = i_tms ? TAP_UPIR  : TAP_PIR;
      TAP_PIR:   w_next = i_tms ? TAP_EX2IR : TAP_PIR;
      TAP_EX2IR: w_next = i_tms ? TAP_UPIR  : TAP_SHIR;
      TAP_UPIR:  w_next = i_tms ? TAP_SELDR : TAP_RTI;
      default:   w_next = TAP_TLR;
    endcase
  end

  assign o_state = r_state;
  assign o_tlr   = (r_state == TAP_TLR);
  assign o_rti   = (r_state == TAP_RTI);
  assign o_capdr = (r_state == TAP_CAPDR);
  assign o_shdr  = (r_state == TAP_SHDR);
  assign o_pdr   = (r_state == TAP_PDR);
  assign o_updr  = (r_state == TAP_UPDR);

endmodule

// File: rtl/peripheral_dbg_tap_multi.sv
// Debug TAP top: IR, IDCODE/USERCODE and bypass registers, instruction decode
// into boundary-scan and user-chain selects, and the falling-edge TDO mux.
module peripheral_dbg_tap_multi
  import peripheral_dbg_tap_pkg::*;
#(
  parameter logic [31:0]          IDCODE_VALUE   = 32'h149511c3,
  parameter logic [31:0]          USERCODE_VALUE = 32'h00000000,
  parameter int                   IR_LENGTH      = 4,
  parameter logic [IR_LENGTH-1:0] IR_CAPTURE     = IR_LENGTH'('b0101),
  parameter int                   CHAIN_BASE     = 8,
  parameter int                   NUM_CHAINS     = 2
) (
  input  logic                  tck_pad_i,
  input  logic                  trst_pad_i,
  peripheral_dbg_tap_multi_if.slave jtag,
  output logic [3:0]            tap_state_o,
  output logic                  test_logic_reset_o,
  output logic                  run_test_idle_o,
  output logic                  capture_dr_o,
  output logic                  shift_dr_o,
  output logic                  pause_dr_o,
  output logic                  update_dr_o,
  output logic                  extest_select_o,
  output logic                  sample_preload_select_o,
  output logic [NUM_CHAINS-1:0] chain_select_o,
  output logic                  tdo_o,
  input  logic                  bs_chain_tdi_i,
  input  logic [NUM_CHAINS-1:0] chain_tdi_i
);

  localparam logic [IR_LENGTH-1:0] L_EXTEST   = IR_LENGTH'(OPC_EXTEST);
  localparam logic [IR_LENGTH-1:0] L_SAMPLE   = IR_LENGTH'(OPC_SAMPLE_PRELOAD);
  localparam logic [IR_LENGTH-1:0] L_IDCODE   = IR_LENGTH'(OPC_IDCODE);
  localparam logic [IR_LENGTH-1:0] L_USERCODE = IR_LENGTH'(OPC_USERCODE);

  tap_state_e w_state;
  logic       w_tlr, w_capdr, w_shdr, w_updr;

  peripheral_dbg_tap_fsm u_fsm (
    .i_tck    (tck_pad_i),
    .i_trst_n (trst_pad_i),
    .i_tms    (jtag.tms_pad_i),
    .o_state  (w_state),
    .o_tlr    (w_tlr),
    .o_rti    (run_test_idle_o),
    .o_capdr  (w_capdr),
    .o_shdr   (w_shdr),
    .o_pdr    (pause_dr_o),
    .o_updr   (w_updr)
  );

  logic [IR_LENGTH-1:0] r_ir_sr;
  logic [IR_LENGTH-1:0] r_ir;
  logic [31:0]          r_id;
  logic                 r_bypass;
  logic                 r_tdo;
  logic                 r_tdo_oe;

  logic                  w_shir;
  logic [IR_LENGTH-1:0]  w_ir_eff;
  logic                  w_sel_ext, w_sel_sp, w_sel_id, w_sel_uc, w_sel_byp;
  logic [NUM_CHAINS-1:0] w_chain_sel;

  assign w_shir = (w_state == TAP_SHIR);

  always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
    if (!trst_pad_i) begin
      r_ir_sr <= IR_CAPTURE;
      r_ir    <= L_IDCODE;
    end else begin
      if (w_state == TAP_CAPIR)   r_ir_sr <= IR_CAPTURE;
      else if (w_shir)            r_ir_sr <= {jtag.tdi_pad_i, r_ir_sr[IR_LENGTH-1:1]};
      if (w_tlr)                  r_ir    <= L_IDCODE;
      else if (w_state == TAP_UPIR) r_ir  <= r_ir_sr;
    end
  end

  always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
    if (!trst_pad_i) begin
      r_id     <= IDCODE_VALUE;
      r_bypass <= 1'b0;
    end else begin
      if (w_capdr) begin
        if (w_sel_id)      r_id <= IDCODE_VALUE;
        else if (w_sel_uc) r_id <= USERCODE_VALUE;
        r_bypass <= 1'b0;
      end else if (w_shdr) begin
        r_id     <= {jtag.tdi_pad_i, r_id[31:1]};
        r_bypass <= jtag.tdi_pad_i;
      end
    end
  end

  // TLR overrides the latched IR immediately so no stale chain select survives a TMS reset.
  assign w_ir_eff = w_tlr ? L_IDCODE : r_ir;

  always_comb begin
    w_chain_sel = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      if (w_ir_eff == IR_LENGTH'(CHAIN_BASE + k)) w_chain_sel[k] = 1'b1;
    end
  end

  assign w_sel_ext = (w_ir_eff == L_EXTEST);
  assign w_sel_sp  = (w_ir_eff == L_SAMPLE);
  assign w_sel_id  = (w_ir_eff == L_IDCODE);
  assign w_sel_uc  = (w_ir_eff == L_USERCODE);
  assign w_sel_byp = ~(w_sel_ext | w_sel_sp | w_sel_id | w_sel_uc | (|w_chain_sel));

  always_ff @(negedge tck_pad_i or negedge trst_pad_i) begin
    if (!trst_pad_i) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo_oe <= w_shir | w_shdr;
      if (w_shir)                        r_tdo <= r_ir_sr[0];
      else if (w_shdr) begin
        if (w_sel_id | w_sel_uc)         r_tdo <= r_id[0];
        else if (w_sel_ext | w_sel_sp)   r_tdo <= bs_chain_tdi_i;
        else if (|w_chain_sel)           r_tdo <= |(w_chain_sel & chain_tdi_i);
        else if (w_sel_byp)              r_tdo <= r_bypass;
      end
    end
  end

  assign jtag.tdo_pad_o          = r_tdo;
  assign jtag.tdo_padoe_o        = r_tdo_oe;
  assign tap_state_o             = w_state;
  assign test_logic_reset_o      = w_tlr;
  assign capture_dr_o            = w_capdr;
  assign shift_dr_o              = w_shdr;
  assign update_dr_o             = w_updr;
  assign extest_select_o         = w_sel_ext;
  assign sample_preload_select_o = w_sel_sp;
  assign chain_select_o          = w_chain_sel;
  assign tdo_o                   = jtag.tdi_pad_i;

endmodule

// File: tb/tb_peripheral_dbg_tap_multi.sv
// Directed bench for the debug TAP: reset, IDCODE/USERCODE scans, IR scans,
// user-chain and bypass data paths, pause/resume, TMS reset and async reset.
module tb_peripheral_dbg_tap_multi;

  logic       tck, trst_n, bs_tdi, tdo_o;
  logic [1:0] chain_tdi, chain_sel;
  logic [3:0] state;
  logic       tlr, rti, capdr, shdr, pdr, updr, ext_sel, sp_sel;
  int         n_checks = 0;
  int         n_fail   = 0;

  peripheral_dbg_tap_multi_if u_if ();

  peripheral_dbg_tap_multi u_dut (
    .tck_pad_i               (tck),
    .trst_pad_i              (trst_n),
    .jtag                    (u_if),
    .tap_state_o             (state),
    .test_logic_reset_o      (tlr),
    .run_test_idle_o         (rti),
    .capture_dr_o            (capdr),
    .shift_dr_o              (shdr),
    .pause_dr_o              (pdr),
    .update_dr_o             (updr),
    .extest_select_o         (ext_sel),
    .sample_preload_select_o (sp_sel),
    .chain_select_o          (chain_sel),
    .tdo_o                   (tdo_o),
    .bs_chain_tdi_i          (bs_tdi),
    .chain_tdi_i             (chain_tdi)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI, let the rising edge act, then let the falling edge update TDO.
  task automatic step(input logic tms, input logic tdi);
    u_if.tms_pad_i = tms;
    u_if.tdi_pad_i = tdi;
    @(posedge tck); #1;
    @(negedge tck); #1;
  endtask

  task automatic ir_scan(input logic [3:0] val, output logic [3:0] cap);
    step(1, 0); step(1, 0); step(0, 0);
    step(0, 0); cap[0] = u_if.tdo_pad_o;
    for (int i = 0; i < 3; i++) begin
      step(0, val[i]); cap[i+1] = u_if.tdo_pad_o;
    end
    step(1, val[3]); step(1, 0); step(0, 0);
  endtask

  task automatic dr_read32(output logic [31:0] v, output logic oe_ok);
    step(1, 0); step(0, 0); step(0, 0);
    v[0] = u_if.tdo_pad_o; oe_ok = u_if.tdo_padoe_o;
    for (int i = 1; i < 32; i++) begin
      step(0, 0); v[i] = u_if.tdo_pad_o; oe_ok &= u_if.tdo_padoe_o;
    end
    step(1, 0); oe_ok &= ~u_if.tdo_padoe_o;
    step(1, 0); step(0, 0);
  endtask

  logic [31:0] rd;
  logic [3:0]  cap;
  logic        oe_ok;
  logic [3:0]  pat;

  initial begin
    trst_n = 1'b0; u_if.tms_pad_i = 1'b1; u_if.tdi_pad_i = 1'b0;
    bs_tdi = 1'b0; chain_tdi = 2'b00;
    repeat (3) @(posedge tck);
    #1 chk("rst_hold_state", state, 4'hF);
    @(negedge tck); #1 trst_n = 1'b1;
    chk("rst_state", state, 4'hF);
    chk("rst_tlr", tlr, 1'b1);
    chk("rst_oe", u_if.tdo_padoe_o, 1'b0);
    chk("rst_tdo", u_if.tdo_pad_o, 1'b0);
    chk("rst_chain_sel", chain_sel, 2'b00);
    chk("rst_bs_sel", {ext_sel, sp_sel}, 2'b00);
    chk("rst_other_decodes", {rti, capdr, shdr, pdr, updr}, 5'b0);

    step(1, 0); chk("tlr_hold", state, 4'hF);
    step(0, 0); chk("rti_state", state, 4'hC); chk("rti_decode", rti, 1'b1);

    dr_read32(rd, oe_ok);
    chk("idcode_scan", rd, 32'h149511c3);
    chk("idcode_oe_window", oe_ok, 1'b1);

    ir_scan(4'h8, cap);
    chk("ir_capture_a", cap, 4'h5);
    chk("chain0_sel", chain_sel, 2'b01);
    chk("after_upir_state", state, 4'hC);

    step(1, 0); step(0, 0);
    chk("capdr_decode", capdr, 1'b1);
    chain_tdi = 2'b01; step(0, 0);
    chk("chain0_tdo_hi", u_if.tdo_pad_o, 1'b1); chk("shdr_decode", shdr, 1'b1);
    chain_tdi = 2'b10; step(0, 0);
    chk("chain0_tdo_lo", u_if.tdo_pad_o, 1'b0);
    step(1, 0); step(0, 0);
    chk("pdr_state", state, 4'h3); chk("pdr_decode", pdr, 1'b1);
    chk("pdr_tdo_hold", u_if.tdo_pad_o, 1'b0);
    chain_tdi = 2'b01; step(1, 0); step(0, 0);
    chk("resume_tdo", u_if.tdo_pad_o, 1'b1);
    step(1, 0); step(1, 0);
    chk("updr_decode", updr, 1'b1);
    step(0, 0);
    chk("updr_one_cycle", updr, 1'b0);

    ir_scan(4'hC, cap);
    chk("ir_capture_b", cap, 4'h5);
    chk("unused_op_sel", {ext_sel, sp_sel, chain_sel}, 4'b0);
    step(1, 0); step(0, 0); step(0, 1);
    chk("bypass_first", u_if.tdo_pad_o, 1'b0);
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(0, pat[i]);
      chk("bypass_delay", u_if.tdo_pad_o, pat[i]);
    end
    step(1, 0); step(1, 0); step(0, 0);

    ir_scan(4'h1, cap);
    chk("sample_sel", {ext_sel, sp_sel, chain_sel}, 4'b0100);
    step(1, 0); step(0, 0);
    bs_tdi = 1'b1; step(0, 0); chk("bs_tdo_hi", u_if.tdo_pad_o, 1'b1);
    bs_tdi = 1'b0; step(0, 0); chk("bs_tdo_lo", u_if.tdo_pad_o, 1'b0);
    step(1, 0); step(1, 0); step(0, 0);

    ir_scan(4'h0, cap);
    chk("extest_sel", {ext_sel, sp_sel, chain_sel}, 4'b1000);

    ir_scan(4'h3, cap);
    dr_read32(rd, oe_ok);
    chk("usercode_scan", rd, 32'h00000000);

    ir_scan(4'h9, cap);
    chk("chain1_sel", chain_sel, 2'b10);
    step(1, 0); step(0, 0); step(0, 0);
    repeat (5) step(1, 0);
    chk("tms_reset_state", state, 4'hF);
    chk("tms_reset_chain_sel", chain_sel, 2'b00);
    step(0, 0);
    chk("tms_reset_ir_idcode", chain_sel, 2'b00);
    chk("tms_reset_rti", state, 4'hC);

    step(1, 0); step(1, 0); step(0, 0); step(0, 1); step(0, 1);
    chk("shir_oe", u_if.tdo_padoe_o, 1'b1);
    #2 trst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 4'hF);
    chk("async_rst_oe", u_if.tdo_padoe_o, 1'b0);
    chk("async_rst_tdo", u_if.tdo_pad_o, 1'b0);
    @(posedge tck); @(negedge tck); #1 trst_n = 1'b1;
    step(0, 0);
    dr_read32(rd, oe_ok);
    chk("post_rst_idcode", rd, 32'h149511c3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
